// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer Gray/binary conversions and output-buffer occupancy encoding shared by FIFO read/write controllers
package fifo_pkg;
  typedef enum logic [1:0] {OCC0 = 2'd0, OCC1 = 2'd1, OCC2 = 2'd2} occ_e;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry FWFT skid buffer; in clk, rst_n, load_i+data_i (tail write), pop_i; out valid_o, data_o (head), occ_o
module fifo_out_buf import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);
  occ_e occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, ent1_q, ent1_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= OCC0;
      head_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      ent1_q <= ent1_d;
    end
  end
  always_comb begin
    occ_d  = load_i && !pop_i ? occ_e'(occ_q + 2'd1) : pop_i && !load_i ? occ_e'(occ_q - 2'd1) : occ_q;
    head_d = load_i && (occ_q == OCC0 || (occ_q == OCC1 && pop_i)) ? data_i :
             pop_i && occ_q == OCC2 ? ent1_q : head_q;
    ent1_d = load_i && (occ_q == OCC1 ? !pop_i : occ_q == OCC2 && pop_i) ? data_i : ent1_q;
  end
  always_comb begin
    valid_o = occ_q != OCC0;
    data_o  = head_q;
    occ_o   = occ_q;
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async-FIFO read side; in r_clk, r_rst_n, write_addr_gray_sync, ram_rd_data, out_ready; out read_addr_gray, ram_rd_en/addr, out_valid/data, empty, rd_level
module fifo_rd_ctrl import fifo_pkg::*; #(
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                    r_clk,
  input  logic                    r_rst_n,
  input  logic [FIFO_DEPTH_BIT:0] write_addr_gray_sync,
  output logic [FIFO_DEPTH_BIT:0] read_addr_gray,
  output logic                    ram_rd_en,
  output logic [FIFO_DEPTH_BIT-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    empty,
  output logic [FIFO_DEPTH_BIT:0] rd_level
);
  localparam int PW = FIFO_DEPTH_BIT + 1;
  logic [PW-1:0] wr_bin, avail, iss_q, iss_d, pop_q, pop_d, rag_q;
  logic inflight_q, pop;
  logic [1:0] occ;
  logic [2:0] need;
  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      iss_q      <= '0;
      pop_q      <= '0;
      rag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      iss_q      <= iss_d;
      pop_q      <= pop_d;
      rag_q      <= PW'(bin2gray(32'(iss_q)));
      inflight_q <= ram_rd_en;
    end
  end
  always_comb begin
    wr_bin         = PW'(gray2bin(32'(write_addr_gray_sync)));
    avail          = wr_bin - iss_q;
    pop            = out_valid && out_ready;
    // slots committed after this edge: buffered + arriving - leaving
    need           = 3'(occ) + 3'(inflight_q) - 3'(pop);
    ram_rd_en      = r_rst_n && avail != '0 && need < 3'd2;
    iss_d          = iss_q + PW'(ram_rd_en);
    pop_d          = pop_q + PW'(pop);
    ram_rd_addr    = iss_q[FIFO_DEPTH_BIT-1:0];
    read_addr_gray = rag_q;
    empty          = avail == '0 && !inflight_q && occ == OCC0;
    rd_level       = wr_bin - pop_q;
  end
  fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk    (r_clk),
    .rst_n  (r_rst_n),
    .load_i (inflight_q),
    .pop_i  (pop),
    .data_i (ram_rd_data),
    .valid_o(out_valid),
    .data_o (out_data),
    .occ_o  (occ)
  );
endmodule
